// File: rtl/divider_seq_pkg.sv
// Shared ALU datapath definitions: opcode codes and divider state encoding.
// Latency: n/a (constants only); backpressure: n/a.
package divider_seq_pkg;

    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_OUT   = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Codes that keep a finished result parked in DONE.
    function automatic logic is_hold_code(input logic [5:0] code,
                                          input logic [5:0] divu,
                                          input logic [5:0] out);
        return (code == divu) || (code == out);
    endfunction

endpackage

// File: rtl/divider_seq_if.sv
// Operand/opcode bus into the divider and result/status bus back out.
// Latency: n/a (wiring only); backpressure: none, the opcode is level-held by the master.
interface divider_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic [5:0]         Signal;
    logic [2*WIDTH-1:0] dataOut;
    logic               busy;
    logic               done;
    logic               divZero;

    modport master (
        output dataA, dataB, Signal,
        input  dataOut, busy, done, divZero
    );

    modport slave (
        input  dataA, dataB, Signal,
        output dataOut, busy, done, divZero
    );
endinterface

// File: rtl/divider_seq_div_step.sv
// One restoring shift-subtract iteration on the {partial remainder, quotient} pair.
// Latency: combinational; backpressure: none.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0]   dvsr,
    output logic [2*WIDTH-1:0] rem_out
);

    // Upper half after the shift is W+1 bits wide so the bit shifted out of the MSB still counts.
    logic [WIDTH:0]   upper;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign upper = rem_in[2*WIDTH-1:WIDTH-1];
    assign fits  = (upper >= {1'b0, dvsr});
    // When fits, the true difference is below dvsr, so W bits hold it exactly.
    assign diff  = upper[WIDTH-1:0] - dvsr;

    assign rem_out = fits ? {diff,              rem_in[WIDTH-2:0], 1'b1}
                          : {upper[WIDTH-1:0], rem_in[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring unsigned divider returning {remainder, quotient} in HI/LO layout.
// Latency: WIDTH iterations after launch (one edge for divide-by-zero); backpressure: DIVU held to run, result parked in DONE.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int         WIDTH = 32,
    parameter logic [5:0] DIVU  = OP_DIVU,
    parameter logic [5:0] OUT   = OP_OUT
) (
    input  logic         clk,
    input  logic         reset,
    divider_seq_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t         state;
    logic [2*WIDTH-1:0] rem;
    logic [2*WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0]   dvsr;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] data_out_q;
    logic               div_zero_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvsr    (dvsr),
        .rem_out (rem_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rem        <= '0;
            dvsr       <= '0;
            count      <= '0;
            data_out_q <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Signal == DIVU) begin
                        if (bus.dataB != '0) begin
                            rem        <= {{WIDTH{1'b0}}, bus.dataA};
                            dvsr       <= bus.dataB;
                            count      <= '0;
                            div_zero_q <= 1'b0;
                            state      <= ST_RUN;
                        end else begin
                            data_out_q <= {bus.dataA, {WIDTH{1'b1}}};
                            div_zero_q <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    // Dropping DIVU abandons the op; the previous result stays visible.
                    if (bus.Signal != DIVU) begin
                        state <= ST_IDLE;
                    end else begin
                        rem   <= rem_nxt;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            data_out_q <= rem_nxt;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // A held DIVU must not retrigger, so only a foreign code leaves DONE.
                    if (!is_hold_code(bus.Signal, DIVU, OUT)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dataOut = data_out_q;
    assign bus.divZero = div_zero_q;
    assign bus.busy    = (state == ST_RUN);
    assign bus.done    = (state == ST_DONE);

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: vector table through a result scoreboard plus timing/abort/reset sequences.
module tb_divider_seq;
    import divider_seq_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    divider_seq_if #(.WIDTH(32)) bus ();

    divider_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_out;
        logic        exp_dz;
    } vec_t;

    typedef struct {
        logic [63:0] out;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.out = {a, 32'hFFFF_FFFF};
            e.dz  = 1'b1;
        end else begin
            e.out = {a % b, a / b};
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        bus.dataA  = a;
        bus.dataB  = b;
        bus.Signal = OP_DIVU;
    endtask

    task automatic push_exp(input logic [63:0] out, input logic dz);
        exp_t e;
        e.out = out;
        e.dz  = dz;
        sb.push_back(e);
    endtask

    // Advance until done, counting edges from (and including) the launch edge.
    task automatic wait_done(input string name, input int max_edges, output int edges);
        edges = 0;
        while (!bus.done && edges < max_edges) begin
            tick();
            edges++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done_after_%0d_edges required=done", name, edges);
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard actual=empty required=entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_dataOut"}, bus.dataOut, e.out);
            chk({name, "_divZero"}, {63'd0, bus.divZero}, {63'd0, e.dz});
        end
    endtask

    task automatic go_idle();
        bus.Signal = 6'd0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        int bad;
        exp_t e;
        string nm;

        vecs[0]  = '{32'd100,        32'd7,          64'h00000002_0000000E, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 1'b0};
        vecs[2]  = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 1'b0};
        vecs[3]  = '{32'd55,         32'd0,          64'h00000037_FFFFFFFF, 1'b1};
        vecs[4]  = '{32'd0,          32'd5,          64'h00000000_00000000, 1'b0};
        vecs[5]  = '{32'd5,          32'd9,          64'h00000005_00000000, 1'b0};
        vecs[6]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001, 1'b0};
        vecs[7]  = '{32'hDEAD_BEEF,  32'h10,         64'h0000000F_0DEADBEE, 1'b0};
        vecs[8]  = '{32'd1000000,    32'd3,          64'h00000001_00051615, 1'b0};
        vecs[9]  = '{32'd0,          32'd0,          64'h00000000_FFFFFFFF, 1'b1};
        vecs[10] = '{32'hFFFF_FFFF,  32'd2,          64'h00000001_7FFFFFFF, 1'b0};
        vecs[11] = '{32'h1234_5678,  32'h1234_5679,  64'h12345678_00000000, 1'b0};

        bus.dataA  = '0;
        bus.dataB  = '0;
        bus.Signal = 6'd0;

        // Reset state.
        #12;
        chk("reset_dataOut", bus.dataOut, 64'd0);
        chk("reset_flags", {61'd0, bus.busy, bus.done, bus.divZero}, 64'd0);
        reset = 1'b1;
        tick();

        // 100/7 with DIVU held: busy after edges 1..32, done after edge 33.
        drive(32'd100, 32'd7);
        e = model(32'd100, 32'd7);
        push_exp(e.out, e.dz);
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 1) begin
                bus.dataA = 32'hDEAD_0000;
                bus.dataB = 32'd1;
            end
            if (!(bus.busy && !bus.done)) bad++;
        end
        chk("run_busy_edges_1_32", bad, 0);
        chk("run_dataOut_held", bus.dataOut, 64'd0);
        tick();
        chk("edge33_busy_done", {62'd0, bus.busy, bus.done}, 64'd1);
        check_result("div_100_7");
        go_idle();
        chk("idle_after_clear", {62'd0, bus.busy, bus.done}, 64'd0);

        // Vector table through the scoreboard, with latency per vector.
        for (int i = 0; i < 12; i++) begin
            nm = $sformatf("vec%0d", i);
            drive(vecs[i].a, vecs[i].b);
            push_exp(vecs[i].exp_out, vecs[i].exp_dz);
            wait_done(nm, 40, edges);
            chk({nm, "_latency"}, edges, (vecs[i].b == 32'd0) ? 64'd1 : 64'd33);
            check_result(nm);
            go_idle();
        end

        // 55/0 followed by an aborted 100/7.
        drive(32'd55, 32'd0);
        tick();
        chk("dz_done_next_edge", {63'd0, bus.done}, 64'd1);
        chk("dz_dataOut", bus.dataOut, 64'h00000037_FFFFFFFF);
        chk("dz_flag", {63'd0, bus.divZero}, 64'd1);
        go_idle();

        drive(32'd100, 32'd7);
        for (int k = 0; k < 11; k++) tick();
        chk("abort_pre_busy", {63'd0, bus.busy}, 64'd1);
        bus.Signal = OP_OUT;
        tick();
        chk("abort_state", {62'd0, bus.busy, bus.done}, 64'd0);
        chk("abort_dataOut_kept", bus.dataOut, 64'h00000037_FFFFFFFF);
        // The launch itself cleared divZero; the abort leaves it there.
        chk("abort_divZero", {63'd0, bus.divZero}, 64'd0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.done) bad++;
        end
        chk("abort_no_done", bad, 0);
        go_idle();

        // Async reset in the middle of a run.
        drive(32'd100, 32'd7);
        for (int k = 0; k < 5; k++) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_dataOut", bus.dataOut, 64'd0);
        chk("async_rst_flags", {61'd0, bus.busy, bus.done, bus.divZero}, 64'd0);
        tick();
        chk("rst_held_flags", {61'd0, bus.busy, bus.done, bus.divZero}, 64'd0);
        #2;
        reset = 1'b1;
        bus.Signal = 6'd0;
        tick();
        drive(32'd9, 32'd3);
        push_exp(64'h00000000_00000003, 1'b0);
        wait_done("after_rst_9_3", 40, edges);
        check_result("after_rst_9_3");

        // DIVU held well past done must not relaunch.
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.busy || !bus.done) bad++;
        end
        chk("held_divu_no_relaunch", bad, 0);
        chk("held_divu_dataOut", bus.dataOut, 64'h00000000_00000003);
        bus.Signal = OP_OUT;
        tick();
        chk("out_keeps_done", {62'd0, bus.busy, bus.done}, 64'd1);
        go_idle();
        chk("leave_done", {62'd0, bus.busy, bus.done}, 64'd0);
        drive(32'd7, 32'd2);
        e = model(32'd7, 32'd2);
        push_exp(e.out, e.dz);
        wait_done("relaunch_7_2", 40, edges);
        chk("relaunch_latency", edges, 64'd33);
        check_result("relaunch_7_2");
        go_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
